// File: rtl/mio_pkg.sv
// mio_pkg: shared constants and helpers for the memory/IO bus stage.
//   - Address map for RAM and the memory-mapped peripherals.
//   - Counter CSR bit positions.
//   - Address decode helper returning a one-of-N target select.
package mio_pkg;

    // RAM occupies any address whose bits [31:12] are zero.
    localparam logic [31:0] RAM_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] DISP_ADDR = 32'hE000_0000;
    localparam logic [31:0] GPIO_ADDR = 32'hF000_0000;
    localparam logic [31:0] CNT_ADDR  = 32'hF000_0004;
    localparam logic [31:0] CSR_ADDR  = 32'hF000_0008;

    localparam int unsigned CSR_EN   = 0;
    localparam int unsigned CSR_AUTO = 1;
    localparam int unsigned CSR_EXP  = 31;

    typedef enum logic [2:0] {
        SelNone,
        SelRam,
        SelDisp,
        SelGpio,
        SelCnt,
        SelCsr
    } sel_e;

    function automatic sel_e decode_addr(input logic [31:0] addr);
        sel_e sel;
        sel = SelNone;
        if ((addr & RAM_MASK) == 32'h0) begin
            sel = SelRam;
        end else if (addr == DISP_ADDR) begin
            sel = SelDisp;
        end else if (addr == GPIO_ADDR) begin
            sel = SelGpio;
        end else if (addr == CNT_ADDR) begin
            sel = SelCnt;
        end else if (addr == CSR_ADDR) begin
            sel = SelCsr;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mio_bus_if.sv
// mio_bus_if: core-side data bus between the RISC-V core and the MIO stage.
//   MemRW     - store strobe from the core
//   addr_bus  - data address from the core
//   cpu_wdata - store data from the core
//   cpu_rdata - load data back to the core (combinational)
//   MIO_ready - always 1, the stage never inserts wait states
interface mio_bus_if;
    logic        MemRW;
    logic [31:0] addr_bus;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        MIO_ready;

    modport master (
        output MemRW,
        output addr_bus,
        output cpu_wdata,
        input  cpu_rdata,
        input  MIO_ready
    );

    modport slave (
        input  MemRW,
        input  addr_bus,
        input  cpu_wdata,
        output cpu_rdata,
        output MIO_ready
    );
endinterface

// File: rtl/mio_counter.sv
// mio_counter: programmable 32-bit down-counter with optional auto-reload.
//   clk, rst      - clock and asynchronous active-high reset
//   load_i        - write strobe for the count/reload register
//   load_val_i    - value loaded into both count and reload
//   csr_we_i      - write strobe for the control/status register
//   csr_wdata_i   - CSR write data (en, auto, write-1-to-clear expired)
//   count_o       - current count
//   en_o, auto_o  - control bits
//   expired_o     - sticky expiry flag
module mio_counter
    import mio_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        csr_we_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] count_o,
    output logic        en_o,
    output logic        auto_o,
    output logic        expired_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] reload_q, reload_d;
    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        expired_q, expired_d;

    // Only the control bits of the CSR write data are architected.
    logic unused_csr_bits;
    assign unused_csr_bits = ^csr_wdata_i[30:2];

    always_comb begin
        count_d   = count_q;
        reload_d  = reload_q;
        en_d      = en_q;
        auto_d    = auto_q;
        expired_d = expired_q;

        if (csr_we_i) begin
            en_d   = csr_wdata_i[CSR_EN];
            auto_d = csr_wdata_i[CSR_AUTO];
            if (csr_wdata_i[CSR_EXP]) begin
                expired_d = 1'b0;
            end
        end

        // Expiry is evaluated after the CSR clear so that a simultaneous set wins.
        if (load_i) begin
            count_d  = load_val_i;
            reload_d = load_val_i;
        end else if (en_q) begin
            if (count_q != 32'h0) begin
                count_d = count_q - 32'h1;
            end else begin
                expired_d = 1'b1;
                if (auto_q) begin
                    count_d = reload_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= 32'h0;
            reload_q  <= 32'h0;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            reload_q  <= reload_d;
            en_q      <= en_d;
            auto_q    <= auto_d;
            expired_q <= expired_d;
        end
    end

    assign count_o   = count_q;
    assign en_o      = en_q;
    assign auto_o    = auto_q;
    assign expired_o = expired_q;

endmodule

// File: rtl/mio_bus.sv
// mio_bus: memory/IO stage behind the single-cycle core. Decodes the core data
// address onto block RAM, LED/switch GPIO, a 7-segment display register and a
// programmable down-counter, and returns load data in the same cycle.
//   clk, rst    - clock and asynchronous active-high reset
//   bus         - core-side bus (slave side)
//   ram_*       - block RAM port, asynchronous read
//   switches    - raw board switches, synchronised internally
//   led         - GPIO output register
//   disp_num    - display register
//   counter_irq - sticky counter expiry flag
module mio_bus
    import mio_pkg::*;
#(
    parameter int unsigned RAM_AW = 10,
    parameter int unsigned IO_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    mio_bus_if.slave          bus,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [IO_W-1:0]   switches,
    output logic [IO_W-1:0]   led,
    output logic [31:0]       disp_num,
    output logic              counter_irq
);

    sel_e sel;
    logic store_gpio, store_disp, store_cnt, store_csr;

    logic [IO_W-1:0] led_q, led_d;
    logic [31:0]     disp_q, disp_d;
    logic [IO_W-1:0] sw_meta_q, sw_sync_q;

    logic [31:0] cnt_count;
    logic        cnt_en, cnt_auto, cnt_expired;
    logic [31:0] rdata;

    assign sel        = decode_addr(bus.addr_bus);
    assign ram_we     = bus.MemRW & (sel == SelRam);
    assign store_gpio = bus.MemRW & (sel == SelGpio);
    assign store_disp = bus.MemRW & (sel == SelDisp);
    assign store_cnt  = bus.MemRW & (sel == SelCnt);
    assign store_csr  = bus.MemRW & (sel == SelCsr);

    assign ram_addr  = bus.addr_bus[RAM_AW+1:2];
    assign ram_wdata = bus.cpu_wdata;

    always_comb begin
        led_d  = led_q;
        disp_d = disp_q;
        if (store_gpio) begin
            led_d = bus.cpu_wdata[IO_W-1:0];
        end
        if (store_disp) begin
            disp_d = bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q     <= '0;
            disp_q    <= 32'h0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            led_q     <= led_d;
            disp_q    <= disp_d;
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
        end
    end

    mio_counter u_counter (
        .clk         (clk),
        .rst         (rst),
        .load_i      (store_cnt),
        .load_val_i  (bus.cpu_wdata),
        .csr_we_i    (store_csr),
        .csr_wdata_i (bus.cpu_wdata),
        .count_o     (cnt_count),
        .en_o        (cnt_en),
        .auto_o      (cnt_auto),
        .expired_o   (cnt_expired)
    );

    // Read mux has no side effects: the core presents an address every cycle.
    always_comb begin
        rdata = 32'h0;
        unique case (sel)
            SelRam:  rdata = ram_rdata;
            SelDisp: rdata = disp_q;
            SelGpio: rdata = 32'(sw_sync_q);
            SelCnt:  rdata = cnt_count;
            SelCsr: begin
                rdata[CSR_EN]   = cnt_en;
                rdata[CSR_AUTO] = cnt_auto;
                rdata[CSR_EXP]  = cnt_expired;
            end
            default: rdata = 32'h0;
        endcase
    end

    assign bus.cpu_rdata = rdata;
    assign bus.MIO_ready = 1'b1;
    assign led           = led_q;
    assign disp_num      = disp_q;
    assign counter_irq   = cnt_expired;

endmodule

// File: tb/tb_mio_bus.sv
// tb_mio_bus: scoreboard bench for mio_bus. Stimulus pushes expected values for
// a chosen DUT output onto a queue; the drain step pops and compares them.
module tb_mio_bus;
    import mio_pkg::*;

    typedef enum logic [2:0] {
        ObsRdata, ObsLed, ObsDisp, ObsIrq, ObsRamWe, ObsRamAddr, ObsRamWdata, ObsReady
    } obs_e;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [15:0] switches;
    logic [15:0] led;
    logic [31:0] disp_num;
    logic        counter_irq;

    mio_bus_if bus_if ();

    mio_bus #(
        .RAM_AW (10),
        .IO_W   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .switches    (switches),
        .led         (led),
        .disp_num    (disp_num),
        .counter_irq (counter_irq)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    obs_e        sel_q[$];
    logic [31:0] exp_q[$];
    string       tag_q[$];

    logic [31:0] os_cnt [6];
    logic [31:0] os_irq [6];
    logic [31:0] ar_cnt [4];
    logic [31:0] ar_irq [4];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic push(input obs_e s, input logic [31:0] e, input string t);
        sel_q.push_back(s);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    // Let combinational outputs settle, then compare everything queued so far.
    task automatic drain;
        obs_e        s;
        logic [31:0] e;
        logic [31:0] a;
        string       t;
        #1;
        while (sel_q.size() > 0) begin
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            case (s)
                ObsRdata:    a = bus_if.cpu_rdata;
                ObsLed:      a = 32'(led);
                ObsDisp:     a = disp_num;
                ObsIrq:      a = 32'(counter_irq);
                ObsRamWe:    a = 32'(ram_we);
                ObsRamAddr:  a = 32'(ram_addr);
                ObsRamWdata: a = ram_wdata;
                default:     a = 32'(bus_if.MIO_ready);
            endcase
            check_eq(t, a, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus_if.MemRW     = we;
        bus_if.addr_bus  = a;
        bus_if.cpu_wdata = d;
    endtask

    initial begin
        os_cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
        os_irq = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
        ar_cnt = '{32'd2, 32'd1, 32'd0, 32'd2};
        ar_irq = '{32'd0, 32'd0, 32'd0, 32'd1};

        rst       = 1'b1;
        ram_rdata = 32'h0;
        switches  = 16'h0;
        bus_drive(1'b0, CNT_ADDR, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        push(ObsLed, 32'h0, "rst_led");
        push(ObsDisp, 32'h0, "rst_disp");
        push(ObsIrq, 32'h0, "rst_irq");
        push(ObsReady, 32'h1, "rst_ready");
        push(ObsRdata, 32'h0, "rst_count");
        drain();
        rst = 1'b0;

        // GPIO store
        bus_drive(1'b1, GPIO_ADDR, 32'h0000_A5A5);
        push(ObsRamWe, 32'h0, "gpio_no_ramwe");
        push(ObsLed, 32'h0, "led_before_edge");
        drain();
        tick();
        bus_drive(1'b0, GPIO_ADDR, 32'h0);
        push(ObsLed, 32'h0000_A5A5, "led_store");
        drain();

        // Display store and readback
        bus_drive(1'b1, DISP_ADDR, 32'hDEAD_BEEF);
        tick();
        bus_drive(1'b0, DISP_ADDR, 32'h0);
        push(ObsDisp, 32'hDEAD_BEEF, "disp_store");
        push(ObsRdata, 32'hDEAD_BEEF, "disp_read");
        drain();

        // RAM store and load
        bus_drive(1'b1, 32'h0000_0010, 32'h1234_5678);
        push(ObsRamWe, 32'h1, "ram_we");
        push(ObsRamAddr, 32'h4, "ram_addr");
        push(ObsRamWdata, 32'h1234_5678, "ram_wdata");
        drain();
        tick();
        bus_drive(1'b0, 32'h0000_0010, 32'h0);
        ram_rdata = 32'hCAFE_F00D;
        push(ObsRamWe, 32'h0, "ram_we_load");
        push(ObsRdata, 32'hCAFE_F00D, "ram_read");
        drain();
        ram_rdata = 32'h0;

        // One-shot countdown from 3
        bus_drive(1'b1, CNT_ADDR, 32'd3);
        tick();
        bus_drive(1'b1, CSR_ADDR, 32'h1);
        tick();
        bus_drive(1'b0, CNT_ADDR, 32'h0);
        for (int i = 0; i < 6; i++) begin
            push(ObsRdata, os_cnt[i], "oneshot_count");
            push(ObsIrq, os_irq[i], "oneshot_irq");
            drain();
            tick();
        end
        bus_drive(1'b0, CSR_ADDR, 32'h0);
        push(ObsRdata, 32'h8000_0001, "csr_read");
        drain();

        // Clear while still expiring (en=1, count=0): set wins, then clear lands
        bus_drive(1'b1, CSR_ADDR, 32'h8000_0000);
        tick();
        push(ObsIrq, 32'h1, "set_beats_clear");
        drain();
        tick();
        push(ObsIrq, 32'h0, "csr_clear");
        drain();

        // Auto-reload with N=2: period of 3
        bus_drive(1'b1, CSR_ADDR, 32'h3);
        tick();
        bus_drive(1'b1, CNT_ADDR, 32'd2);
        tick();
        bus_drive(1'b0, CNT_ADDR, 32'h0);
        for (int i = 0; i < 4; i++) begin
            push(ObsRdata, ar_cnt[i], "auto_count");
            push(ObsIrq, ar_irq[i], "auto_irq");
            drain();
            tick();
        end
        // count is 1 here: a clear on this non-expiry edge takes effect
        bus_drive(1'b1, CSR_ADDR, 32'h8000_0003);
        tick();
        push(ObsIrq, 32'h0, "clear_nonexpiry");
        drain();
        // count is 0 here: the expiry edge beats the clear
        tick();
        push(ObsIrq, 32'h1, "clear_on_expiry");
        drain();
        bus_drive(1'b0, CNT_ADDR, 32'h0);
        push(ObsRdata, 32'd2, "auto_reload");
        drain();

        // Stop counter: this edge still decrements 2 -> 1, then it holds
        bus_drive(1'b1, CSR_ADDR, 32'h0);
        tick();

        // Switch synchroniser
        switches = 16'h00FF;
        bus_drive(1'b0, GPIO_ADDR, 32'h0);
        push(ObsRdata, 32'h0, "sw_0edge");
        drain();
        tick();
        push(ObsRdata, 32'h0, "sw_1edge");
        drain();
        tick();
        push(ObsRdata, 32'h0000_00FF, "sw_2edge");
        drain();

        // Unmapped address
        bus_drive(1'b0, 32'hF000_000C, 32'h0);
        push(ObsRdata, 32'h0, "unmapped_read");
        drain();
        bus_drive(1'b1, 32'hF000_000C, 32'hFFFF_FFFF);
        push(ObsRamWe, 32'h0, "unmapped_ramwe");
        drain();
        tick();
        bus_drive(1'b0, CNT_ADDR, 32'h0);
        push(ObsLed, 32'h0000_A5A5, "unmapped_led");
        push(ObsDisp, 32'hDEAD_BEEF, "unmapped_disp");
        push(ObsRdata, 32'd1, "unmapped_count");
        push(ObsIrq, 32'h1, "unmapped_irq");
        drain();

        // Asynchronous reset mid-count
        bus_drive(1'b1, CNT_ADDR, 32'd7);
        tick();
        bus_drive(1'b1, CSR_ADDR, 32'h1);
        tick();
        bus_drive(1'b0, CNT_ADDR, 32'h0);
        push(ObsRdata, 32'd7, "pre_rst_count");
        drain();
        #1;
        rst = 1'b1;
        #1;
        push(ObsRdata, 32'h0, "async_rst_count");
        push(ObsLed, 32'h0, "async_rst_led");
        push(ObsDisp, 32'h0, "async_rst_disp");
        push(ObsIrq, 32'h0, "async_rst_irq");
        drain();
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        push(ObsRdata, 32'h0, "idle_after_rst");
        push(ObsIrq, 32'h0, "irq_after_rst");
        drain();
        bus_drive(1'b0, CSR_ADDR, 32'h0);
        push(ObsRdata, 32'h0, "csr_after_rst");
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
